// File: rtl/eth_crc_pkg.sv
// ---------------------------------------------------------------------------
// eth_crc_pkg
// Shared definitions for the Ethernet CRC-32 stream engine.
//   CRC32_POLY     generator polynomial (MSB-first form)
//   CRC32_INIT     register value at the start of every frame
//   CRC32_RESIDUE  register value after data + correct FCS have been folded in
//   crc_state_t    APPEND-path state: forwarding data, or emitting FCS beats
//   bitrev8        reverses a byte so the wire-order LSB is fed first
//   crc32_byte     one byte through the MSB-first CRC register (8 unrolled steps)
// ---------------------------------------------------------------------------
package eth_crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_FCS  = 1'b1
    } crc_state_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] data);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = data[7-i];
        end
        return r;
    endfunction

    // The caller passes an already bit-reversed byte, so data[7] is the
    // first bit seen on the wire. The loop unrolls into the 8-bit XOR matrix.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_lanes.sv
// ---------------------------------------------------------------------------
// eth_crc32_lanes
// Combinational fold of up to BYTES byte lanes into the CRC register.
// Lane 0 is folded first. Only the lanes enabled by keep contribute; keep is
// contiguous from lane 0, so its popcount picks the matching chain tap.
//   crc_in   [31:0]        current CRC register
//   data     [8*BYTES-1:0] byte lanes, lane i = data[8i+7:8i]
//   keep     [BYTES-1:0]   lane-valid mask
//   crc_out  [31:0]        CRC after the enabled lanes
// ---------------------------------------------------------------------------
module eth_crc32_lanes
    import eth_crc_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic [31:0]        crc_in,
    input  logic [8*BYTES-1:0] data,
    input  logic [BYTES-1:0]   keep,
    output logic [31:0]        crc_out
);

    localparam int CW = $clog2(BYTES + 1);

    logic [31:0]   stage [BYTES+1];
    logic [CW-1:0] count;

    // Serial chain of byte steps; stage[i] holds the CRC after i lanes.
    always_comb begin
        stage[0] = crc_in;
        for (int i = 0; i < BYTES; i++) begin
            stage[i+1] = crc32_byte(stage[i], bitrev8(data[8*i +: 8]));
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < BYTES; i++) begin
            count = count + CW'(keep[i]);
        end
    end

    // Tap selection by lane count; zero lanes leaves the register unchanged.
    always_comb begin
        crc_out = crc_in;
        for (int i = 1; i <= BYTES; i++) begin
            if (count == CW'(i)) begin
                crc_out = stage[i];
            end
        end
    end

endmodule

// File: rtl/eth_crc32_stream.sv
// ---------------------------------------------------------------------------
// eth_crc32_stream
// Ethernet CRC-32 engine on a valid/ready byte-lane stream.
//   APPEND=1: forwards the frame, then appends the 4-byte FCS as extra beats.
//   APPEND=0: forwards the frame unchanged and reports FCS good/bad.
// Parameters
//   BYTES   byte lanes per beat (1, 2 or 4); lane 0 is earliest on the wire
//   APPEND  1 = generate and append FCS, 0 = check the FCS in the frame
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   s_valid/s_ready             input handshake
//   s_data/s_keep/s_last        input beat, lane mask, end of frame
//   m_valid/m_ready             output handshake (registered, 1-cycle latency)
//   m_data/m_keep/m_last        output beat, lane mask, end of frame
//   crc_done/crc_ok             check result pulse and verdict (APPEND=0)
//   crc_value                   running CRC register
// ---------------------------------------------------------------------------
module eth_crc32_stream
    import eth_crc_pkg::*;
#(
    parameter int BYTES  = 4,
    parameter int APPEND = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*BYTES-1:0] s_data,
    input  logic [BYTES-1:0]   s_keep,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [8*BYTES-1:0] m_data,
    output logic [BYTES-1:0]   m_keep,
    output logic               m_last,
    output logic               crc_done,
    output logic               crc_ok,
    output logic [31:0]        crc_value
);

    localparam int              DW        = 8 * BYTES;
    localparam int              FCS_BEATS = 4 / BYTES;
    localparam int              CW        = $clog2(FCS_BEATS + 1);
    localparam logic [BYTES-1:0] KEEP_ALL = '1;

    crc_state_t    state;
    crc_state_t    state_next;
    logic [31:0]   crc_reg;
    logic [31:0]   crc_next;
    logic [31:0]   fcs_reg;
    logic [31:0]   fcs_latch;
    logic [DW-1:0] fcs_beat;
    logic [CW-1:0] beat_cnt;
    logic          out_adv;
    logic          accept;
    logic          fcs_emit;
    logic          fcs_finish;

    // The output register may take a new beat when empty or being drained.
    assign out_adv   = !m_valid || m_ready;
    assign s_ready   = !rst && (state == ST_DATA) && out_adv;
    assign accept    = s_valid && s_ready;
    assign crc_value = crc_reg;

    eth_crc32_lanes #(
        .BYTES (BYTES)
    ) u_lanes (
        .crc_in  (crc_reg),
        .data    (s_data),
        .keep    (s_keep),
        .crc_out (crc_next)
    );

    // FCS byte k is the complemented, bit-reversed k-th register byte from the top.
    always_comb begin
        fcs_latch = '0;
        for (int k = 0; k < 4; k++) begin
            fcs_latch[8*k +: 8] = ~bitrev8(crc_next[31-8*k -: 8]);
        end
    end

    // FCS byte 0 goes out first, so each beat takes the next DW bits from the bottom.
    always_comb begin
        fcs_beat = DW'(fcs_reg >> (DW * int'(beat_cnt)));
    end

    // Next-state and FCS beat strobes. In FCS, once every beat has been
    // loaded, an advance of the output register means the final beat was taken.
    always_comb begin
        state_next = state;
        fcs_emit   = 1'b0;
        fcs_finish = 1'b0;
        case (state)
            ST_DATA: begin
                if ((APPEND != 0) && accept && s_last) begin
                    state_next = ST_FCS;
                end
            end
            ST_FCS: begin
                if (out_adv) begin
                    if (int'(beat_cnt) < FCS_BEATS) begin
                        fcs_emit = 1'b1;
                    end else begin
                        fcs_finish = 1'b1;
                        state_next = ST_DATA;
                    end
                end
            end
            default: state_next = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DATA;
        end else begin
            state <= state_next;
        end
    end

    // CRC register, FCS latch and beat counter. The register returns to its
    // initial value on the same edge that captures the frame's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg  <= CRC32_INIT;
            fcs_reg  <= '0;
            beat_cnt <= '0;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            if (accept) begin
                if (s_last) begin
                    crc_reg <= CRC32_INIT;
                    if (APPEND != 0) begin
                        fcs_reg  <= fcs_latch;
                        beat_cnt <= '0;
                    end else begin
                        crc_done <= 1'b1;
                        crc_ok   <= (crc_next == CRC32_RESIDUE);
                    end
                end else begin
                    crc_reg <= crc_next;
                end
            end
            if (fcs_emit) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    // Single output register. In APPEND mode the last data beat is forwarded
    // without m_last because FCS beats follow it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_keep  <= s_keep;
                m_last  <= (APPEND != 0) ? 1'b0 : s_last;
            end else if (fcs_emit) begin
                m_valid <= 1'b1;
                m_data  <= fcs_beat;
                m_keep  <= KEEP_ALL;
                m_last  <= (int'(beat_cnt) == FCS_BEATS - 1);
            end else if (fcs_finish || (state == ST_DATA && out_adv)) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_crc32_stream.sv
// ---------------------------------------------------------------------------
// tb_eth_crc32_stream
// Two engines side by side: an APPEND engine with 4 lanes and a CHECK
// engine with 2 lanes. Expected beats and verdicts come from a reflected
// LSB-first CRC-32 model and are queued when a frame is issued; monitors
// pop and compare whenever an output beat is handshaked or crc_done fires.
// ---------------------------------------------------------------------------
module tb_eth_crc32_stream;

    localparam int AB = 4;
    localparam int CB = 2;

    typedef logic [7:0] bytes_t [$];
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, rst_c;
    logic            a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last, a_crc_done, a_crc_ok;
    logic [8*AB-1:0] a_s_data, a_m_data;
    logic [AB-1:0]   a_s_keep, a_m_keep;
    logic [31:0]     a_crc_value;
    logic            c_s_valid, c_s_ready, c_s_last, c_m_valid, c_m_ready, c_m_last, c_crc_done, c_crc_ok;
    logic [8*CB-1:0] c_s_data, c_m_data;
    logic [CB-1:0]   c_s_keep, c_m_keep;
    logic [31:0]     c_crc_value;

    int    vectors = 0;
    int    miscompares = 0;
    int    stalls = 0;
    int    a_bp = 0;
    int    c_bp = 0;
    beat_t a_exp[$];
    beat_t c_exp[$];
    logic  c_ok_exp[$];
    bit    a_stalled = 1'b0;
    bit    c_stalled = 1'b0;
    logic [63:0] a_prev, c_prev;

    eth_crc32_stream #(.BYTES(AB), .APPEND(1)) u_app (
        .clk(clk), .rst(rst_a),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_keep(a_s_keep), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_keep(a_m_keep), .m_last(a_m_last),
        .crc_done(a_crc_done), .crc_ok(a_crc_ok), .crc_value(a_crc_value)
    );

    eth_crc32_stream #(.BYTES(CB), .APPEND(0)) u_chk (
        .clk(clk), .rst(rst_c),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data), .s_keep(c_s_keep), .s_last(c_s_last),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .m_keep(c_m_keep), .m_last(c_m_last),
        .crc_done(c_crc_done), .crc_ok(c_crc_ok), .crc_value(c_crc_value)
    );

    // Reference: reflected CRC-32 (poly 0xEDB88320), LSB of each byte first.
    function automatic logic [31:0] ref_crc(input bytes_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bytes_t with_fcs(input bytes_t d);
        bytes_t r;
        logic [31:0] f;
        r = d;
        f = ref_crc(d);
        for (int k = 0; k < 4; k++) begin
            r.push_back(f[8*k +: 8]);
        end
        return r;
    endfunction

    function automatic bytes_t rand_frame(input int n);
        bytes_t r;
        for (int i = 0; i < n; i++) begin
            r.push_back(8'($urandom));
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected response for a frame, then drive its beats.
    task automatic apply_stimulus(input bit chk, input bytes_t frame, input bit hold);
        int          nb, n, nbeats, waitc;
        bit          acc;
        beat_t       bt;
        beat_t       beats[$];
        logic [31:0] fcs, rx, mask;
        nb     = chk ? CB : AB;
        n      = frame.size();
        nbeats = (n + nb - 1) / nb;
        for (int b = 0; b < nbeats; b++) begin
            bt = '0;
            bt.last = (b == nbeats - 1);
            for (int i = 0; i < nb; i++) begin
                if (b * nb + i < n) begin
                    bt.data[8*i +: 8] = frame[b * nb + i];
                    bt.keep[i] = 1'b1;
                end
            end
            beats.push_back(bt);
            if (chk) begin
                c_exp.push_back(bt);
            end else begin
                bt.last = 1'b0;
                a_exp.push_back(bt);
            end
        end
        if (chk) begin
            rx = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
            c_ok_exp.push_back(ref_crc(frame[0:n-5]) == rx);
        end else begin
            fcs  = ref_crc(frame);
            mask = (AB == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * AB)) - 32'd1);
            for (int j = 0; j < 4 / AB; j++) begin
                bt.data = (fcs >> (8 * AB * j)) & mask;
                bt.keep = 4'((1 << AB) - 1);
                bt.last = (j == 4 / AB - 1);
                a_exp.push_back(bt);
            end
        end
        foreach (beats[b]) begin
            if (chk) begin
                c_s_valid = 1'b1;
                c_s_data  = beats[b].data[8*CB-1:0];
                c_s_keep  = beats[b].keep[CB-1:0];
                c_s_last  = beats[b].last;
            end else begin
                a_s_valid = 1'b1;
                a_s_data  = beats[b].data[8*AB-1:0];
                a_s_keep  = beats[b].keep[AB-1:0];
                a_s_last  = beats[b].last;
            end
            waitc = 0;
            do begin
                @(negedge clk);
                acc = chk ? c_s_ready : a_s_ready;
                step();
                waitc++;
            end while (!acc && waitc < 300);
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL accept_timeout: beat %0d not accepted after %0d cycles, required accept", b, waitc);
                break;
            end
            stalls += waitc - 1;
        end
        if (!hold) begin
            if (chk) c_s_valid = 1'b0;
            else     a_s_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((a_exp.size() != 0 || c_exp.size() != 0 || c_ok_exp.size() != 0) && t < 500) begin
            step();
            t++;
        end
        vectors++;
        if (t >= 500) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d/%0d/%0d entries still queued, required 0", a_exp.size(), c_exp.size(), c_ok_exp.size());
        end
        step();
        step();
    endtask

    // Downstream ready patterns: 0 always ready, 1 toggle, 2 random, 3 manual.
    initial begin
        a_m_ready = 1'b1;
        c_m_ready = 1'b1;
        forever begin
            step();
            case (a_bp)
                0: a_m_ready = 1'b1;
                1: a_m_ready = !a_m_ready;
                2: a_m_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
            case (c_bp)
                0: c_m_ready = 1'b1;
                1: c_m_ready = !c_m_ready;
                2: c_m_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // APPEND monitor: handshaked beats against the queue, held beats must not move.
    always @(negedge clk) begin
        beat_t e;
        if (rst_a) begin
            a_stalled = 1'b0;
        end else begin
            if (a_stalled) begin
                check_output("a_stall_hold", {26'd0, a_m_valid, a_m_last, a_m_keep, a_m_data}, a_prev);
            end
            if (a_m_valid && a_m_ready) begin
                if (a_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL a_extra_beat: got data %h with nothing expected", a_m_data);
                end else begin
                    e = a_exp.pop_front();
                    check_output("a_beat", {27'd0, a_m_data, a_m_keep, a_m_last}, {27'd0, e.data, e.keep, e.last});
                end
            end
            a_stalled = a_m_valid && !a_m_ready;
            a_prev    = {26'd0, a_m_valid, a_m_last, a_m_keep, a_m_data};
        end
    end

    // CHECK monitor: pass-through beats plus crc_done/crc_ok verdicts.
    always @(negedge clk) begin
        beat_t e;
        logic  ok;
        if (rst_c) begin
            c_stalled = 1'b0;
        end else begin
            if (c_stalled) begin
                check_output("c_stall_hold", {44'd0, c_m_valid, c_m_last, c_m_keep, c_m_data}, c_prev);
            end
            if (c_m_valid && c_m_ready) begin
                if (c_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL c_extra_beat: got data %h with nothing expected", c_m_data);
                end else begin
                    e = c_exp.pop_front();
                    check_output("c_beat", {27'd0, 16'd0, c_m_data, 2'b00, c_m_keep, c_m_last}, {27'd0, e.data, e.keep, e.last});
                end
            end
            if (c_crc_done) begin
                check_output("c_done_align", {62'd0, c_m_valid, c_m_last}, 64'd3);
                if (c_ok_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL c_extra_done: got crc_done with no frame outstanding");
                end else begin
                    ok = c_ok_exp.pop_front();
                    check_output("c_crc_ok", {63'd0, c_crc_ok}, {63'd0, ok});
                end
            end
            c_stalled = c_m_valid && !c_m_ready;
            c_prev    = {44'd0, c_m_valid, c_m_last, c_m_keep, c_m_data};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bytes_t s9, s9f, bad, f1, f2;
        rst_a = 1'b1; rst_c = 1'b1;
        a_s_valid = 1'b0; a_s_data = '0; a_s_keep = '0; a_s_last = 1'b0;
        c_s_valid = 1'b0; c_s_data = '0; c_s_keep = '0; c_s_last = 1'b0;
        for (int i = 0; i < 9; i++) s9.push_back(8'(8'h31 + i));
        s9f = with_fcs(s9);
        bad = s9f;
        bad[3] = bad[3] ^ 8'h01;

        // Reset state
        step();
        check_output("a_rst_s_ready", {63'd0, a_s_ready}, 64'd0);
        check_output("c_rst_s_ready", {63'd0, c_s_ready}, 64'd0);
        check_output("a_rst_out", {26'd0, a_m_valid, a_m_last, a_m_keep, a_m_data}, 64'd0);
        check_output("a_rst_crc", {32'd0, a_crc_value}, 64'hFFFFFFFF);
        check_output("c_rst_done", {62'd0, c_crc_done, c_crc_ok}, 64'd0);
        step();
        rst_a = 1'b0; rst_c = 1'b0;
        #1;
        check_output("a_s_ready_after_rst", {63'd0, a_s_ready}, 64'd1);
        step();

        $display("[TB] known vectors, always ready");
        apply_stimulus(1'b0, s9, 1'b0);
        apply_stimulus(1'b1, s9f, 1'b0);
        drain();
        check_output("a_crc_idle", {32'd0, a_crc_value}, 64'hFFFFFFFF);
        check_output("c_crc_idle", {32'd0, c_crc_value}, 64'hFFFFFFFF);
        apply_stimulus(1'b1, bad, 1'b0);
        drain();

        $display("[TB] toggling backpressure");
        a_bp = 1; c_bp = 1;
        apply_stimulus(1'b0, s9, 1'b0);
        apply_stimulus(1'b1, s9f, 1'b0);
        apply_stimulus(1'b1, bad, 1'b0);
        drain();

        $display("[TB] back-to-back 64-byte frames");
        a_bp = 0; c_bp = 0;
        step();
        f1 = rand_frame(64);
        f2 = rand_frame(64);
        apply_stimulus(1'b0, f1, 1'b1);
        apply_stimulus(1'b0, f2, 1'b0);
        drain();
        stalls = 0;
        apply_stimulus(1'b1, with_fcs(f1), 1'b1);
        apply_stimulus(1'b1, with_fcs(f2), 1'b0);
        check_output("c_b2b_stalls", 64'(stalls), 64'd0);
        drain();

        $display("[TB] random frames, random backpressure");
        a_bp = 2; c_bp = 2;
        for (int it = 0; it < 16; it++) begin
            bytes_t d, cf;
            d = rand_frame($urandom_range(1, 40));
            apply_stimulus(1'b0, d, 1'b0);
            cf = with_fcs(rand_frame($urandom_range(1, 40)));
            if ($urandom_range(0, 1) == 1) begin
                int p;
                p = $urandom_range(0, cf.size() - 1);
                cf[p] = cf[p] ^ 8'(1 << $urandom_range(0, 7));
            end
            apply_stimulus(1'b1, cf, 1'b0);
        end
        drain();

        $display("[TB] reset while the FCS beat is presented");
        a_bp = 3;
        a_m_ready = 1'b0;
        apply_stimulus(1'b0, rand_frame(4), 1'b0);
        a_m_ready = 1'b1;
        step();
        a_m_ready = 1'b0;
        #1;
        rst_a = 1'b1;
        a_exp.delete();
        #1;
        check_output("a_midrst_valid", {63'd0, a_m_valid}, 64'd0);
        check_output("a_midrst_crc", {32'd0, a_crc_value}, 64'hFFFFFFFF);
        check_output("a_midrst_s_ready", {63'd0, a_s_ready}, 64'd0);
        step();
        rst_a = 1'b0;
        a_bp = 0;
        step();
        apply_stimulus(1'b0, s9, 1'b0);
        apply_stimulus(1'b0, rand_frame(23), 1'b0);
        drain();
        check_output("a_crc_final", {32'd0, a_crc_value}, 64'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
